// File: rtl/vga_timing_rx.sv
// vga_timing_rx
//   Recovers pixel coordinates from a DE/HSYNC/VSYNC video stream, measures
//   the stream's line and frame timing, and reports when that timing is stable.
//
// Ports
//   clk_pix    in   pixel clock (only clock)
//   rst_pix_n  in   asynchronous active-low reset
//   hsync      in   horizontal sync, low during sync
//   vsync      in   vertical sync, low during sync
//   de         in   data enable, high in the active area
//   de_o       out  de delayed two clocks, aligned with sx/sy
//   sx, sy     out  active-area column / row of the pixel flagged by de_o
//   h_total    out  clocks per line of the last accepted frame
//   h_active   out  de clocks per active line of the last accepted frame
//   v_total    out  lines per frame of the last accepted frame
//   v_active   out  active lines per frame of the last accepted frame
//   locked     out  timing stable
//   line       out  one-cycle strobe after each hsync falling edge
//   frame      out  one-cycle strobe after each vsync falling edge
//   mismatch   out  one-cycle strobe when a locked stream's timing changes
module vga_timing_rx #(
  parameter int CORDW = 11
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic             de_o,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic [CORDW-1:0] h_total,
  output logic [CORDW-1:0] h_active,
  output logic [CORDW-1:0] v_total,
  output logic [CORDW-1:0] v_active,
  output logic             locked,
  output logic             line,
  output logic             frame,
  output logic             mismatch
);

  localparam logic [CORDW-1:0] MAX = '1;
  localparam logic [CORDW-1:0] ONE = CORDW'(1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t state_q, state_d;

  logic hs_q, vs_q, de_q, hs_qq, vs_qq;
  logic line_edge, frame_edge, h_sat;

  logic [CORDW-1:0] h_cnt, de_cnt, v_cnt, v_act_cnt, h_tot_m, h_act_m;
  logic             have_htot, have_hact, incon;

  logic [CORDW-1:0] cand_ht, cand_ha, cand_vt, cand_va;
  logic             cand_valid, cand_ok;

  logic [CORDW-1:0] f_ht, f_ha, f_vt, f_va;
  logic             f_ok, line_has_de, line_bad, f_same_cand, f_same_out;
  logic             upd_out, mis_d, latch_cand, clr_cand;

  logic             pend_x, pend_y, first_px;

  function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v, input logic en);
    return (en && (v != MAX)) ? v + ONE : v;
  endfunction

  // Sync registers reset to the idle (high) level so that releasing reset
  // never looks like a sync falling edge.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_qq <= 1'b1;
      de_q  <= 1'b0;
    end else begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      hs_qq <= hs_q;
      vs_qq <= vs_q;
      de_q  <= de;
    end
  end

  assign line_edge  = hs_qq & ~hs_q;
  assign frame_edge = vs_qq & ~vs_q;
  // A line edge in this cycle means hsync is alive even if h_cnt topped out.
  assign h_sat      = (h_cnt == MAX) & ~line_edge;

  // Frame summary including the line closing this cycle, so a coincident
  // line+frame edge counts that line into the frame being closed.
  assign line_has_de = (de_cnt != '0);
  assign line_bad    = line_edge &
                       ((have_htot & (h_cnt != h_tot_m)) |
                        (line_has_de & have_hact & (de_cnt != h_act_m)));
  assign f_ht = have_htot ? h_tot_m : (line_edge ? h_cnt : '0);
  assign f_ha = have_hact ? h_act_m : ((line_edge & line_has_de) ? de_cnt : '0);
  assign f_vt = sat_inc(v_cnt, line_edge);
  assign f_va = sat_inc(v_act_cnt, line_edge & line_has_de);
  assign f_ok = ~incon & ~line_bad;

  // Locking needs the previous candidate to have been consistent too, so two
  // back-to-back clean frames are always required.
  assign f_same_cand = cand_valid & cand_ok & f_ok &
                       (f_ht == cand_ht) & (f_ha == cand_ha) &
                       (f_vt == cand_vt) & (f_va == cand_va);
  assign f_same_out  = (f_ht == h_total) & (f_ha == h_active) &
                       (f_vt == v_total) & (f_va == v_active);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      h_cnt  <= '0;
      de_cnt <= '0;
    end else if (line_edge) begin
      h_cnt  <= ONE;
      de_cnt <= de_q ? ONE : '0;
    end else begin
      h_cnt  <= sat_inc(h_cnt, 1'b1);
      de_cnt <= sat_inc(de_cnt, de_q);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      v_cnt     <= '0;
      v_act_cnt <= '0;
      h_tot_m   <= '0;
      h_act_m   <= '0;
      have_htot <= 1'b0;
      have_hact <= 1'b0;
      incon     <= 1'b0;
    end else if (frame_edge) begin
      v_cnt     <= '0;
      v_act_cnt <= '0;
      h_tot_m   <= '0;
      h_act_m   <= '0;
      have_htot <= 1'b0;
      have_hact <= 1'b0;
      incon     <= 1'b0;
    end else if (line_edge) begin
      v_cnt     <= f_vt;
      v_act_cnt <= f_va;
      incon     <= incon | line_bad;
      if (!have_htot) begin
        h_tot_m   <= h_cnt;
        have_htot <= 1'b1;
      end
      if (line_has_de && !have_hact) begin
        h_act_m   <= de_cnt;
        have_hact <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    upd_out    = 1'b0;
    mis_d      = 1'b0;
    latch_cand = 1'b0;
    clr_cand   = 1'b0;
    if (h_sat) begin
      state_d = SEARCH;
    end else if (frame_edge) begin
      case (state_q)
        SEARCH: begin
          state_d  = MEASURE;
          clr_cand = 1'b1;
        end
        MEASURE: begin
          latch_cand = 1'b1;
          if (f_same_cand) begin
            state_d = LOCKED;
            upd_out = 1'b1;
          end
        end
        LOCKED: begin
          latch_cand = 1'b1;
          if (!f_ok || !f_same_out) begin
            state_d = MEASURE;
            mis_d   = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q    <= SEARCH;
      cand_ht    <= '0;
      cand_ha    <= '0;
      cand_vt    <= '0;
      cand_va    <= '0;
      cand_valid <= 1'b0;
      cand_ok    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr_cand) begin
        cand_valid <= 1'b0;
        cand_ok    <= 1'b0;
      end else if (latch_cand) begin
        cand_ht    <= f_ht;
        cand_ha    <= f_ha;
        cand_vt    <= f_vt;
        cand_va    <= f_va;
        cand_valid <= 1'b1;
        cand_ok    <= f_ok;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      locked   <= 1'b0;
      line     <= 1'b0;
      frame    <= 1'b0;
      mismatch <= 1'b0;
      h_total  <= '0;
      h_active <= '0;
      v_total  <= '0;
      v_active <= '0;
    end else begin
      locked   <= (state_d == LOCKED);
      line     <= line_edge;
      frame    <= frame_edge;
      mismatch <= mis_d;
      if (upd_out) begin
        h_total  <= f_ht;
        h_active <= f_ha;
        v_total  <= f_vt;
        v_active <= f_va;
      end
    end
  end

  // pend_x/pend_y remember that the next de pixel starts a new line / the
  // first active line of a frame; both start set so the first pixel after
  // reset is (0,0).
  assign first_px = de_q & (pend_x | line_edge);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      de_o   <= 1'b0;
      sx     <= '0;
      sy     <= '0;
      pend_x <= 1'b1;
      pend_y <= 1'b1;
    end else begin
      de_o <= de_q;
      if (de_q) begin
        sx     <= first_px ? '0 : sat_inc(sx, 1'b1);
        pend_x <= 1'b0;
      end else if (line_edge) begin
        pend_x <= 1'b1;
      end
      if (first_px) begin
        sy     <= (pend_y | frame_edge) ? '0 : sat_inc(sy, 1'b1);
        pend_y <= 1'b0;
      end else if (frame_edge) begin
        pend_y <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx
//   Drives small randomized video timings into vga_timing_rx and compares
//   every output, every cycle, against a frame-level reference model.
module tb_vga_timing_rx;

  localparam int CORDW = 11;
  localparam int MAXV  = 2047;

  logic             clk_pix = 1'b0;
  logic             rst_pix_n;
  logic             hsync, vsync, de;
  logic             de_o, locked, line, frame, mismatch;
  logic [CORDW-1:0] sx, sy, h_total, h_active, v_total, v_active;

  vga_timing_rx #(.CORDW(CORDW)) dut (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .de_o     (de_o),
    .sx       (sx),
    .sy       (sy),
    .h_total  (h_total),
    .h_active (h_active),
    .v_total  (v_total),
    .v_active (v_active),
    .locked   (locked),
    .line     (line),
    .frame    (frame),
    .mismatch (mismatch)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    int ht;
    int ha;
    int vt;
    int va;
    bit ok;
  } rec_t;

  typedef struct {
    bit de_o;
    int sx;
    int sy;
    bit line;
    bit frame;
    bit mismatch;
    bit locked;
    int ht;
    int ha;
    int vt;
    int va;
  } snap_t;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: stream-level facts, not DUT registers.
  bit    m_prev_hs, m_prev_vs, m_search, m_locked, m_have_prev;
  int    m_line_de, m_active_lines, m_x, m_y, m_since_line;
  rec_t  m_prev, m_out, last_rec;
  snap_t pipe[$];

  int base_ht, base_ha, base_vt, base_va;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit same_rec(input rec_t a, input rec_t b);
    return (a.ht == b.ht) && (a.ha == b.ha) && (a.vt == b.vt) && (a.va == b.va);
  endfunction

  function automatic snap_t zero_snap();
    snap_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic model_reset();
    m_prev_hs      = 1'b1;
    m_prev_vs      = 1'b1;
    m_search       = 1'b1;
    m_locked       = 1'b0;
    m_have_prev    = 1'b0;
    m_line_de      = 0;
    m_active_lines = 0;
    m_x            = 0;
    m_y            = 0;
    m_since_line   = 0;
    m_prev         = '{default: 0};
    m_out          = '{default: 0};
    pipe.delete();
    pipe.push_back(zero_snap());
    pipe.push_back(zero_snap());
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_locked"},   locked,   0);
    checkOutput({pfx, "_de_o"},     de_o,     0);
    checkOutput({pfx, "_sx"},       sx,       0);
    checkOutput({pfx, "_sy"},       sy,       0);
    checkOutput({pfx, "_h_total"},  h_total,  0);
    checkOutput({pfx, "_v_active"}, v_active, 0);
    checkOutput({pfx, "_line"},     line,     0);
    checkOutput({pfx, "_frame"},    frame,    0);
    checkOutput({pfx, "_mismatch"}, mismatch, 0);
  endtask

  // One pixel clock: check outputs owed from two cycles ago, drive the new
  // pixel, and advance the model.
  task automatic applyStimulus(input bit hs, input bit vs, input bit d);
    snap_t s;
    bit    line_b, frame_b, mis;
    @(negedge clk_pix);
    s = pipe.pop_front();
    checkOutput("de_o",     de_o,     s.de_o);
    checkOutput("sx",       sx,       s.sx);
    checkOutput("sy",       sy,       s.sy);
    checkOutput("line",     line,     s.line);
    checkOutput("frame",    frame,    s.frame);
    checkOutput("mismatch", mismatch, s.mismatch);
    checkOutput("locked",   locked,   s.locked);
    checkOutput("h_total",  h_total,  s.ht);
    checkOutput("h_active", h_active, s.ha);
    checkOutput("v_total",  v_total,  s.vt);
    checkOutput("v_active", v_active, s.va);

    hsync = hs;
    vsync = vs;
    de    = d;

    line_b    = m_prev_hs && !hs;
    frame_b   = m_prev_vs && !vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    mis       = 1'b0;

    if (line_b) m_since_line = 0;
    else if (m_since_line < MAXV) m_since_line++;

    if (!line_b && m_since_line >= MAXV) begin
      m_search = 1'b1;
      m_locked = 1'b0;
    end else if (frame_b) begin
      if (m_search) begin
        m_search    = 1'b0;
        m_have_prev = 1'b0;
      end else if (m_locked) begin
        if (!last_rec.ok || !same_rec(last_rec, m_out)) begin
          mis      = 1'b1;
          m_locked = 1'b0;
        end
        m_prev      = last_rec;
        m_have_prev = 1'b1;
      end else begin
        if (m_have_prev && m_prev.ok && last_rec.ok && same_rec(last_rec, m_prev)) begin
          m_locked = 1'b1;
          m_out    = last_rec;
        end
        m_prev      = last_rec;
        m_have_prev = 1'b1;
      end
    end

    if (line_b)  m_line_de = 0;
    if (frame_b) m_active_lines = 0;
    if (d) begin
      if (m_line_de == 0) begin
        m_x = 0;
        m_y = m_active_lines;
        m_active_lines++;
      end else begin
        m_x++;
      end
      m_line_de++;
    end

    s.de_o     = d;
    s.sx       = m_x;
    s.sy       = m_y;
    s.line     = line_b;
    s.frame    = frame_b;
    s.mismatch = mis;
    s.locked   = m_locked;
    s.ht       = m_out.ht;
    s.ha       = m_out.ha;
    s.vt       = m_out.vt;
    s.va       = m_out.va;
    pipe.push_back(s);
  endtask

  task automatic mid_reset();
    @(negedge clk_pix);
    rst_pix_n = 1'b0;
    hsync     = 1'b1;
    vsync     = 1'b1;
    de        = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    model_reset();
  endtask

  // Frame layout: hsync low for 4 clocks at line start, de from clock 10;
  // vsync low for lines 0-1, active lines from line 4. short_line makes that
  // active line one de clock short; abort_line resets the DUT at that line.
  task automatic send_frame(input int ht, input int ha, input int vt, input int va,
                            input int short_line, input int abort_line);
    int len;
    for (int l = 0; l < vt; l++) begin
      if (l == abort_line) begin
        mid_reset();
        return;
      end
      len = ((l - 4) == short_line) ? ha - 1 : ha;
      for (int c = 0; c < ht; c++) begin
        applyStimulus(c >= 4, l >= 2, (l >= 4) && (l < 4 + va) && (c >= 10) && (c < 10 + len));
      end
    end
    last_rec = '{ht: ht, ha: ha, vt: vt, va: va, ok: (short_line < 0)};
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send_frame(base_ht, base_ha, base_vt, base_va, -1, -1);
  endtask

  task automatic check_locked_to_base(input string pfx);
    checkOutput({pfx, "_locked"},   locked,   1);
    checkOutput({pfx, "_h_total"},  h_total,  base_ht);
    checkOutput({pfx, "_h_active"}, h_active, base_ha);
    checkOutput({pfx, "_v_total"},  v_total,  base_vt);
    checkOutput({pfx, "_v_active"}, v_active, base_va);
  endtask

  initial begin
    int kind;
    rst_pix_n = 1'b0;
    hsync     = 1'b1;
    vsync     = 1'b1;
    de        = 1'b0;
    last_rec  = '{default: 0};

    base_ht = 40 + $urandom_range(0, 16);
    base_ha = $urandom_range(16, base_ht - 12);
    base_vt = $urandom_range(10, 14);
    base_va = $urandom_range(3, base_vt - 5);
    $display("[TB] timing ht=%0d ha=%0d vt=%0d va=%0d", base_ht, base_ha, base_vt, base_va);

    repeat (3) @(negedge clk_pix);
    checkAllZero("reset");
    rst_pix_n = 1'b1;
    model_reset();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);

    // Initial lock on the third vsync fall.
    send_good(4);
    check_locked_to_base("first_lock");

    // Random mix of good, longer-line and short-active-line frames.
    for (int i = 0; i < 14; i++) begin
      kind = $urandom_range(0, 7);
      if (kind == 0)
        send_frame(base_ht + 1, base_ha, base_vt, base_va, -1, -1);
      else if (kind == 1)
        send_frame(base_ht, base_ha, base_vt, base_va, $urandom_range(1, base_va - 1), -1);
      else
        send_good(1);
    end
    send_good(3);
    check_locked_to_base("random_mix");

    // One longer-line frame while locked, then relock after two good frames.
    send_frame(base_ht + 1, base_ha, base_vt, base_va, -1, -1);
    send_good(3);
    check_locked_to_base("relock_after_long");

    // Lost hsync: counter saturates and lock drops, then relock on restart.
    repeat (2100) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("hsync_lost_locked", locked, 0);
    send_good(4);
    check_locked_to_base("relock_after_loss");

    // Reset mid-frame of a locked stream, then relock from scratch.
    send_frame(base_ht, base_ha, base_vt, base_va, -1, 5);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
    send_good(4);
    check_locked_to_base("relock_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
